// File: rtl/bmem_line_arbiter.sv
// Round-robin arbiter that moves whole cache lines between NUM_CH requesters
// and a single burst memory port. A line is carried as LINE_W/BURST_W beats:
// reads are reassembled into a shared line buffer, writes are sliced from a
// latched copy of the requester's line.
//
// Handshake semantics (both sides):
//   Requester side: ch_read/ch_write are level requests, held (with address and
//   wdata stable) until ch_resp pulses for one cycle; the requester drops the
//   request on the edge after it samples ch_resp. ch_rdata is valid in that
//   ch_resp cycle and holds until the next read completes.
//   Memory side: bmem_read/bmem_write and bmem_address stay asserted and stable
//   for the whole burst; every cycle with bmem_resp=1 retires exactly one beat,
//   and gaps of any length between beats are allowed.
module bmem_line_arbiter #(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_address,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*LINE_W-1:0]   ch_wdata,
  output logic [LINE_W-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [ADDR_W-1:0]          bmem_address,
  output logic                       bmem_read,
  output logic                       bmem_write,
  output logic [BURST_W-1:0]         bmem_wdata,
  input  logic [BURST_W-1:0]         bmem_rdata,
  input  logic                       bmem_resp,
  output logic [1:0]                 dbg_state
);

  localparam int BEATS  = LINE_W / BURST_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OFF_W  = $clog2(LINE_W / 8);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [CH_W:0]     NUM_CH_L  = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CH_W-1:0]     rr_q;
  logic [CH_W-1:0]     gnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   line_q;
  logic [LINE_W-1:0]   rdata_q;
  logic [BEAT_W-1:0]   beat_q;

  logic [NUM_CH-1:0]   pending;
  logic [2*NUM_CH-1:0] pend_rot;
  logic                gnt_found;
  logic [CH_W-1:0]     gnt_ofs;
  logic [CH_W:0]       gnt_sum;
  logic [CH_W:0]       gnt_wrap;
  logic [CH_W-1:0]     gnt_idx;
  logic [CH_W:0]       rr_sum;
  logic [CH_W-1:0]     rr_next;
  logic [LINE_W-1:0]   line_merged;
  logic                last_beat;

  assign pending   = ch_read | ch_write;
  assign pend_rot  = {pending, pending} >> rr_q;
  assign last_beat = bmem_resp && (beat_q == LAST_BEAT);
  assign ch_rdata  = rdata_q;
  assign dbg_state = state_q;

  // Round-robin pick: first pending channel at or after rr_q, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ofs   = '0;
    for (int j = NUM_CH - 1; j >= 0; j--) begin
      if (pend_rot[j]) begin
        gnt_found = 1'b1;
        gnt_ofs   = CH_W'(j);
      end
    end
    gnt_sum  = {1'b0, rr_q} + {1'b0, gnt_ofs};
    gnt_wrap = gnt_sum - NUM_CH_L;
    gnt_idx  = (gnt_sum >= NUM_CH_L) ? gnt_wrap[CH_W-1:0] : gnt_sum[CH_W-1:0];
    rr_sum   = {1'b0, gnt_q} + (CH_W + 1)'(1);
    rr_next  = (rr_sum >= NUM_CH_L) ? '0 : rr_sum[CH_W-1:0];
  end

  // Line buffer with the incoming beat merged in, so the final beat lands in ch_rdata.
  always_comb begin
    line_merged = line_q;
    line_merged[beat_q*BURST_W +: BURST_W] = bmem_rdata;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state and all port outputs; outputs are zero unless the state drives them.
  always_comb begin
    state_d      = state_q;
    bmem_read    = 1'b0;
    bmem_write   = 1'b0;
    bmem_address = '0;
    bmem_wdata   = '0;
    ch_resp      = '0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) state_d = ch_write[gnt_idx] ? S_WR : S_RD;
      end
      S_RD: begin
        bmem_read    = 1'b1;
        bmem_address = addr_q & LINE_MASK;
        if (last_beat) state_d = S_DONE;
      end
      S_WR: begin
        bmem_write   = 1'b1;
        bmem_address = addr_q & LINE_MASK;
        bmem_wdata   = wdata_q[beat_q*BURST_W +: BURST_W];
        if (last_beat) state_d = S_DONE;
      end
      S_DONE: begin
        ch_resp[gnt_q] = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grant latching, beat counting, read-line assembly and pointer advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q    <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            gnt_q  <= gnt_idx;
            addr_q <= ch_address[gnt_idx*ADDR_W +: ADDR_W];
            beat_q <= '0;
            if (ch_write[gnt_idx]) wdata_q <= ch_wdata[gnt_idx*LINE_W +: LINE_W];
          end
        end
        S_RD: begin
          if (bmem_resp) begin
            line_q <= line_merged;
            beat_q <= beat_q + BEAT_W'(1);
            if (beat_q == LAST_BEAT) rdata_q <= line_merged;
          end
        end
        S_WR: begin
          if (bmem_resp) beat_q <= beat_q + BEAT_W'(1);
        end
        S_DONE: begin
          rr_q <= rr_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bmem_line_arbiter.sv
// Bench for bmem_line_arbiter: directed scenarios with hand-computed results,
// then randomized requesters and memory against a transaction-level model.
module tb_bmem_line_arbiter;

  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*LINE_W-1:0] ch_wdata;
  logic [LINE_W-1:0]        ch_rdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic [ADDR_W-1:0]        bmem_address;
  logic                     bmem_read;
  logic                     bmem_write;
  logic [BURST_W-1:0]       bmem_wdata;
  logic [BURST_W-1:0]       bmem_rdata;
  logic                     bmem_resp;
  logic [1:0]               dbg_state;

  bmem_line_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BURST_W(BURST_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_address(ch_address), .ch_read(ch_read), .ch_write(ch_write),
    .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_resp(ch_resp),
    .bmem_address(bmem_address), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_rdata(bmem_rdata), .bmem_resp(bmem_resp),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [NUM_CH-1:0] seen_resp = '0;

  string             lit_name_q[$];
  logic [LINE_W-1:0] lit_act_q[$];
  logic [LINE_W-1:0] lit_exp_q[$];

  bit                sc_resp_q[$];
  logic [BURST_W-1:0] sc_data_q[$];
  logic [BURST_W-1:0] wbeats[$];

  bit rand_req = 0;
  bit rand_mem = 0;
  bit keep_req = 0;

  // ---------------- reference model (transaction level) ----------------
  // phase 0: waiting for a grant, 1: line transfer in progress, 2: completion cycle
  int                m_phase = 0;
  int                m_rr    = 0;
  int                m_ch    = 0;
  int                m_cnt   = 0;
  bit                m_wr    = 0;
  logic [ADDR_W-1:0] m_addr  = '0;
  logic [LINE_W-1:0] m_wdata = '0;
  logic [LINE_W-1:0] m_rdata = '0;
  logic [BURST_W-1:0] m_line[BEATS];

  always @(posedge clk or negedge rst) begin : model_blk
    int found;
    int pick;
    int cand;
    logic [LINE_W-1:0] asm_line;
    if (!rst) begin
      m_phase <= 0;
      m_rr    <= 0;
      m_cnt   <= 0;
      m_rdata <= '0;
    end else begin
      case (m_phase)
        0: begin
          found = 0;
          pick  = 0;
          for (int k = 0; k < NUM_CH; k++) begin
            cand = (m_rr + k) % NUM_CH;
            if (found == 0 && (ch_read[cand] || ch_write[cand])) begin
              found = 1;
              pick  = cand;
            end
          end
          if (found != 0) begin
            m_phase <= 1;
            m_ch    <= pick;
            m_wr    <= ch_write[pick];
            m_addr  <= ch_address[pick*ADDR_W +: ADDR_W];
            m_wdata <= ch_wdata[pick*LINE_W +: LINE_W];
            m_cnt   <= 0;
          end
        end
        1: begin
          if (bmem_resp) begin
            for (int b = 0; b < BEATS; b++)
              asm_line[b*BURST_W +: BURST_W] = (b == m_cnt) ? bmem_rdata : m_line[b];
            if (!m_wr) m_line[m_cnt] <= bmem_rdata;
            m_cnt <= m_cnt + 1;
            if (m_cnt == BEATS - 1) begin
              m_phase <= 2;
              if (!m_wr) m_rdata <= asm_line;
            end
          end
        end
        default: begin
          m_rr    <= (m_ch + 1) % NUM_CH;
          m_phase <= 0;
        end
      endcase
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare_blk
    logic                e_rd;
    logic                e_wr;
    logic [ADDR_W-1:0]   e_addr;
    logic [BURST_W-1:0]  e_wdata;
    logic [NUM_CH-1:0]   e_resp;
    e_rd    = 1'b0;
    e_wr    = 1'b0;
    e_addr  = '0;
    e_wdata = '0;
    e_resp  = '0;
    if (m_phase == 1) begin
      e_rd   = !m_wr;
      e_wr   = m_wr;
      e_addr = m_addr - ADDR_W'(m_addr % (LINE_W / 8));
      if (m_wr) e_wdata = m_wdata[m_cnt*BURST_W +: BURST_W];
    end else if (m_phase == 2) begin
      e_resp = NUM_CH'(1) << m_ch;
    end
    check("bmem_read", LINE_W'(bmem_read), LINE_W'(e_rd));
    check("bmem_write", LINE_W'(bmem_write), LINE_W'(e_wr));
    check("bmem_address", LINE_W'(bmem_address), LINE_W'(e_addr));
    check("bmem_wdata", LINE_W'(bmem_wdata), LINE_W'(e_wdata));
    check("ch_resp", LINE_W'(ch_resp), LINE_W'(e_resp));
    check("ch_rdata", ch_rdata, m_rdata);
    seen_resp = ch_resp;
    while (lit_name_q.size() > 0)
      check(lit_name_q.pop_front(), lit_act_q.pop_front(), lit_exp_q.pop_front());
  end

  task automatic push_lit(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    lit_name_q.push_back(name);
    lit_act_q.push_back(act);
    lit_exp_q.push_back(exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input int c, input bit rd, input bit wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd);
    ch_read[c]  = rd;
    ch_write[c] = wr;
    ch_address[c*ADDR_W +: ADDR_W] = a;
    ch_wdata[c*LINE_W +: LINE_W]   = wd;
  endtask

  task automatic sc_add(input bit r, input logic [BURST_W-1:0] d);
    sc_resp_q.push_back(r);
    sc_data_q.push_back(d);
  endtask

  task automatic drive_cycle();
    bit dropped[NUM_CH];
    logic [LINE_W-1:0] wd;
    int kind;
    for (int c = 0; c < NUM_CH; c++) begin
      dropped[c] = 0;
      if (seen_resp[c] && !keep_req) begin
        ch_read[c]  = 1'b0;
        ch_write[c] = 1'b0;
        dropped[c]  = 1;
      end
    end
    if (rand_req) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!dropped[c] && !ch_read[c] && !ch_write[c] && $urandom_range(0, 3) == 0) begin
          for (int w = 0; w < LINE_W / 32; w++) wd[w*32 +: 32] = $urandom();
          kind = $urandom_range(0, 2);
          issue(c, kind != 1, kind != 0, $urandom(), wd);
        end
      end
      // Address wiggle on the granted channel after grant must have no effect.
      if (m_phase == 1 && $urandom_range(0, 7) == 0)
        ch_address[m_ch*ADDR_W +: ADDR_W] = $urandom();
    end
    if (sc_resp_q.size() > 0) begin
      bmem_resp  = sc_resp_q.pop_front();
      bmem_rdata = sc_data_q.pop_front();
    end else if (rand_mem) begin
      bmem_resp  = ($urandom_range(0, 2) != 0);
      bmem_rdata = {$urandom(), $urandom()};
    end else begin
      bmem_resp  = 1'b0;
      bmem_rdata = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_cycle();
  endtask

  task automatic wait_resp(input int budget, output int k, output logic [NUM_CH-1:0] r,
                           output logic [ADDR_W-1:0] a1, output logic rd1, output logic wr1);
    k = 0; r = '0; a1 = '0; rd1 = 1'b0; wr1 = 1'b0;
    wbeats.delete();
    while (r == '0 && k < budget) begin
      tick();
      k++;
      @(negedge clk);
      if (k == 1) begin
        a1  = bmem_address;
        rd1 = bmem_read;
        wr1 = bmem_write;
      end
      if (bmem_write && bmem_resp) wbeats.push_back(bmem_wdata);
      r = ch_resp;
    end
  endtask

  // ---------------- stimulus ----------------
  localparam logic [LINE_W-1:0] LINE1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [LINE_W-1:0] WLINE = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

  initial begin
    int                k;
    int                guard;
    logic [NUM_CH-1:0] r;
    logic [ADDR_W-1:0] a1;
    logic              rd1;
    logic              wr1;
    logic [BURST_W-1:0] exp_beat;

    rst = 1'b1; ch_address = '0; ch_read = '0; ch_write = '0; ch_wdata = '0;
    bmem_rdata = '0; bmem_resp = 1'b0;
    #1 rst = 1'b0;
    tick(); tick();
    @(negedge clk);
    push_lit("reset_resp", LINE_W'(ch_resp), '0);
    push_lit("reset_read", LINE_W'(bmem_read), '0);
    push_lit("reset_rdata", ch_rdata, '0);
    push_lit("reset_state", LINE_W'(dbg_state), '0);
    tick();
    rst = 1'b1;

    // Single read, back-to-back beats.
    sc_add(0, '0);
    sc_add(1, 64'h1111_1111_1111_1111); sc_add(1, 64'h2222_2222_2222_2222);
    sc_add(1, 64'h3333_3333_3333_3333); sc_add(1, 64'h4444_4444_4444_4444);
    tick();
    issue(0, 1, 0, 32'h0000_1234, '0);
    wait_resp(20, k, r, a1, rd1, wr1);
    push_lit("t1_latency", LINE_W'(k), LINE_W'(5));
    push_lit("t1_resp", LINE_W'(r), LINE_W'(3'b001));
    push_lit("t1_addr", LINE_W'(a1), LINE_W'(32'h0000_1220));
    push_lit("t1_read", LINE_W'(rd1), LINE_W'(1));
    push_lit("t1_rdata", ch_rdata, LINE1);

    // Write beat order on ch1.
    sc_add(0, '0);
    for (int i = 0; i < 4; i++) sc_add(1, {$urandom(), $urandom()});
    tick();
    issue(1, 0, 1, 32'h0000_0040, WLINE);
    wait_resp(20, k, r, a1, rd1, wr1);
    push_lit("t2_latency", LINE_W'(k), LINE_W'(5));
    push_lit("t2_resp", LINE_W'(r), LINE_W'(3'b010));
    push_lit("t2_write", LINE_W'(wr1), LINE_W'(1));
    push_lit("t2_addr", LINE_W'(a1), LINE_W'(32'h0000_0040));
    push_lit("t2_nbeats", LINE_W'(wbeats.size()), LINE_W'(4));
    for (int i = 0; i < 4; i++) begin
      exp_beat = {16{4'(4'hA + i)}};
      push_lit("t2_beat", (i < wbeats.size()) ? LINE_W'(wbeats[i]) : '0, LINE_W'(exp_beat));
    end
    push_lit("t2_rdata_kept", ch_rdata, LINE1);

    // Stalled read: resp pattern 1,0,0,1,0,1,1.
    sc_add(0, '0);
    sc_add(1, 64'h0A0A_0A0A_0A0A_0A0A); sc_add(0, '0); sc_add(0, '0);
    sc_add(1, 64'h0B0B_0B0B_0B0B_0B0B); sc_add(0, '0);
    sc_add(1, 64'h0C0C_0C0C_0C0C_0C0C); sc_add(1, 64'h0D0D_0D0D_0D0D_0D0D);
    tick();
    issue(2, 1, 0, 32'hABCD_EF7F, '0);
    wait_resp(30, k, r, a1, rd1, wr1);
    push_lit("t3_latency", LINE_W'(k), LINE_W'(8));
    push_lit("t3_resp", LINE_W'(r), LINE_W'(3'b100));
    push_lit("t3_addr", LINE_W'(a1), LINE_W'(32'hABCD_EF60));
    push_lit("t3_rdata", ch_rdata, {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                                    64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A});

    // Fairness: ch1 alone, then ch0+ch1 together -> ch0 then ch1.
    rand_mem = 1;
    tick();
    issue(1, 1, 0, $urandom(), '0);
    wait_resp(60, k, r, a1, rd1, wr1);
    push_lit("t4_alone", LINE_W'(r), LINE_W'(3'b010));
    tick(); tick();
    issue(0, 1, 0, $urandom(), '0);
    issue(1, 1, 0, $urandom(), '0);
    wait_resp(60, k, r, a1, rd1, wr1);
    push_lit("t4_first", LINE_W'(r), LINE_W'(3'b001));
    wait_resp(60, k, r, a1, rd1, wr1);
    push_lit("t4_second", LINE_W'(r), LINE_W'(3'b010));

    // Stray bmem_resp while idle, then read+write together on ch0.
    tick(); tick();
    sc_add(1, '1); sc_add(1, '1); sc_add(1, '1);
    tick(); tick(); tick();
    @(negedge clk);
    push_lit("t5_stray_state", LINE_W'(dbg_state), '0);
    push_lit("t5_stray_read", LINE_W'(bmem_read), '0);
    tick();
    issue(0, 1, 1, 32'h0000_8000, {8{$urandom()}});
    wait_resp(60, k, r, a1, rd1, wr1);
    push_lit("t5_rw_resp", LINE_W'(r), LINE_W'(3'b001));
    push_lit("t5_rw_write", LINE_W'(wr1), LINE_W'(1));
    push_lit("t5_rw_read", LINE_W'(rd1), LINE_W'(0));

    // Reset two beats into a read; pointer must return to 0.
    tick(); tick();
    sc_add(0, '0); sc_add(1, {$urandom(), $urandom()}); sc_add(1, {$urandom(), $urandom()});
    sc_add(0, '0); sc_add(0, '0);
    tick();
    issue(0, 1, 0, 32'h0000_2000, '0);
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    push_lit("t6_async_read", LINE_W'(bmem_read), '0);
    push_lit("t6_async_addr", LINE_W'(bmem_address), '0);
    push_lit("t6_async_resp", LINE_W'(ch_resp), '0);
    push_lit("t6_async_rdata", ch_rdata, '0);
    ch_read = '0; ch_write = '0;
    sc_resp_q.delete(); sc_data_q.delete();
    tick(); tick();
    rst = 1'b1;
    tick();
    issue(0, 1, 0, 32'h0000_3000, '0);
    issue(2, 1, 0, 32'h0000_4000, '0);
    wait_resp(60, k, r, a1, rd1, wr1);
    push_lit("t6_after_first", LINE_W'(r), LINE_W'(3'b001));
    wait_resp(60, k, r, a1, rd1, wr1);
    push_lit("t6_after_second", LINE_W'(r), LINE_W'(3'b100));

    // All three held continuously from rr=0: grants 0,1,2,0.
    tick(); tick();
    keep_req = 1;
    issue(0, 1, 0, $urandom(), '0);
    issue(1, 1, 0, $urandom(), '0);
    issue(2, 1, 0, $urandom(), '0);
    for (int i = 0; i < 4; i++) begin
      wait_resp(60, k, r, a1, rd1, wr1);
      push_lit("t7_order", LINE_W'(r), LINE_W'(NUM_CH'(1) << (i % 3)));
    end
    keep_req = 0;
    wait_resp(60, k, r, a1, rd1, wr1);
    push_lit("t7_tail1", LINE_W'(r), LINE_W'(3'b010));
    wait_resp(60, k, r, a1, rd1, wr1);
    push_lit("t7_tail2", LINE_W'(r), LINE_W'(3'b100));

    // Randomized traffic.
    rand_req = 1;
    for (int i = 0; i < 3000; i++) tick();
    rand_req = 0;
    guard = 0;
    while (((ch_read | ch_write) != '0 || m_phase != 0) && guard < 300) begin
      tick();
      guard++;
    end
    push_lit("drain_idle", LINE_W'(ch_read | ch_write), '0);
    tick(); tick(); tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bmem_line_arbiter.md
Name: bmem_line_arbiter

Overview:
- Parametrised successor to the single-path cache-to-burst-memory hookup in mp3.
- Arbitrates NUM_CH cache-line requesters (e.g. I-cache, D-cache, prefetcher) onto one burst memory port.
- Splits each LINE_W line into BEATS = LINE_W/BURST_W bursts, and reassembles them on reads.
- Sits between the cache array(s) and burst_memory; is synthesizable RTL, not a testbench component.

Parameters:
NUM_CH, 2, number of requesting channels (>=1)
ADDR_W, 32, address width
LINE_W, 256, cache line width in bits
BURST_W, 64, burst memory data width; LINE_W/BURST_W is a power of 2, >=1

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
ch_address  in  NUM_CH x ADDR_W  per-channel line address
ch_read  in  NUM_CH  per-channel line read request, held until ch_resp
ch_write  in  NUM_CH  per-channel line write request, held until ch_resp
ch_wdata  in  NUM_CH x LINE_W  per-channel write line, stable while request held
ch_rdata  out  LINE_W  shared read line buffer, valid in the ch_resp cycle
ch_resp  out  NUM_CH  one-hot, one-cycle completion pulse
bmem_address  out  ADDR_W  line-aligned burst address
bmem_read  out  1  burst read request
bmem_write  out  1  burst write request
bmem_wdata  out  BURST_W  current write beat
bmem_rdata  in  BURST_W  read beat, valid when bmem_resp=1
bmem_resp  in  1  beat acknowledge

Behaviour:
- Reset (rst=0, async):
  - State=IDLE, rr_ptr=0, beat=0.
  - All outputs 0, including ch_rdata.
  - An in-flight burst is abandoned; no ch_resp is issued for it.
- FSM states: IDLE, RD, WR, DONE.
- IDLE:
  - Pending set = ch_read | ch_write.
  - Grant = first pending channel searching rr_ptr, rr_ptr+1, ... mod NUM_CH.
  - On grant: latch channel index, address and wdata (if write); beat=0.
  - If ch_write is set for the channel -> WR, else -> RD. If read and write are both set, write wins.
  - No pending -> stay in IDLE.
- RD:
  - bmem_read=1; bmem_address = latched address with low log2(LINE_W/8) bits forced to 0.
  - Each cycle with bmem_resp=1: line_buf[beat*BURST_W +: BURST_W] <= bmem_rdata; beat++.
  - The beat on which beat == BEATS-1 and bmem_resp=1 -> DONE.
- WR:
  - bmem_write=1, same address rule as RD.
  - bmem_wdata = latched_wdata[beat*BURST_W +: BURST_W].
  - Each cycle with bmem_resp=1: beat++. Final beat -> DONE.
- Stalls: bmem_resp may have gaps of any length; bmem_read/bmem_write and the address stay asserted and stable across the whole burst.
- DONE:
  - bmem_read=bmem_write=0.
  - ch_resp[granted]=1 for exactly this cycle; ch_rdata = line_buf.
  - rr_ptr <= (granted+1) mod NUM_CH; -> IDLE.
- Requester contract: deassert the request on the edge after sampling ch_resp; it is therefore low by the following IDLE cycle.
- Latency: request seen in IDLE cycle 0; bmem request from cycle 1. With back-to-back resp, ch_resp arrives in cycle BEATS+1.
- Post-DONE re-grant: a requester that keeps its request high after ch_resp is re-granted only through normal round-robin (treated as a new request).
- ch_rdata holds its value until the next RD completion; write completions do not alter it.
- Ignored inputs:
  - bmem_resp outside RD/WR is ignored.
  - Request or address changes from the granted channel after grant are ignored, since the latched copy is used.
- Channel isolation: non-granted requests wait with no effect. Starvation is bounded by NUM_CH-1 intervening transactions.
- Beat counter width: max(1, log2(BEATS)). When BEATS=1, every transaction is a single beat.

Test Plan:
- Single read: ch0 read addr 0x0000_1234, memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back. Required: bmem_address=0x0000_1220; ch_resp[0] in cycle 5; ch_rdata = {0x44..,0x33..,0x22..,0x11..}.
- Write beat order: ch1 write addr 0x40, wdata = {0xD..,0xC..,0xB..,0xA..}. Required: bmem_wdata sequence 0xA..,0xB..,0xC..,0xD..; ch_resp[1] after the 4th resp; ch_rdata unchanged.
- Fairness:
  - ch1 read alone, then ch0 and ch1 asserted together -> ch0 served first, then ch1.
  - NUM_CH=3, all three held continuously -> grant order 0,1,2,0 (assuming rr_ptr=0 at the start).
- Stalls: read with bmem_resp pattern 1,0,0,1,0,1,1. Required: bmem_read and address stable throughout; correct beat placement; ch_resp one cycle after the 4th resp.
- Reset mid-burst: rst=0 after 2 beats of a read. Required: all outputs 0 immediately (asynchronous); no ch_resp for the aborted read. After release, a new ch0 request completes normally with rr_ptr=0.
- Read+write both set on ch0 -> write burst only. Stray bmem_resp in IDLE -> no state change.
